// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned operands.
// Fixed latency: WIDTH CALC cycles, then a one-cycle done pulse.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Q
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     mcand, mplier, addend, a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc, acc_nx;
    logic [WIDTH:0]       sum;
    logic [CW-1:0]        cnt;
    logic                 neg, load, finish;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(1)) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the
    // correct unsigned magnitude in WIDTH bits.
    assign a_mag  = (is_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag  = (is_signed && B[WIDTH-1]) ? -B : B;

    assign addend = mplier[0] ? mcand : '0;
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign acc_nx = {sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            Q      <= '0;
        end else if (load) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc    <= '0;
            cnt    <= CW'(WIDTH);
        end else if (busy) begin
            acc    <= acc_nx;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (finish) Q <= neg ? -acc_nx : acc_nx;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed checks of seq_multiplier (WIDTH=16 and WIDTH=4)
// against an arithmetic reference product.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        st16, sg16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] q16;
    logic        st4, sg4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  q4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .is_signed(sg16),
        .A(a16), .B(b16), .busy(busy16), .done(done16), .Q(q16)
    );

    seq_multiplier #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .is_signed(sg4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .Q(q4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Product of two w-bit operands, low 2w bits, from plain integer arithmetic.
    function automatic logic [63:0] ref_mul(input longint a, input longint b, input bit s, input int w);
        longint pa = a;
        longint pb = b;
        longint half = longint'(1) << (w - 1);
        longint mask = (longint'(1) << (2 * w)) - 1;
        if (s) begin
            if (pa >= half) pa -= (longint'(1) << w);
            if (pb >= half) pb -= (longint'(1) << w);
        end
        return 64'((pa * pb) & mask);
    endfunction

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit s, input string tag);
        int n = 0;
        int bad = 0;
        @(negedge clk);
        a16 = a; b16 = b; sg16 = s; st16 = 1'b1;
        @(posedge clk);
        #1;
        st16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sg16 = 1'($urandom);
        while (n <= 40) begin
            @(negedge clk);
            n++;
            if (done16) break;
            if (!busy16) bad++;
        end
        check({tag, "_lat"}, 64'(n), 64'd17);
        check({tag, "_busy"}, 64'(bad), 64'd0);
        check({tag, "_q"}, 64'(q16), ref_mul(longint'(a), longint'(b), s, 16));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done16), 64'd0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit s);
        int n = 0;
        @(negedge clk);
        a4 = a; b4 = b; sg4 = s; st4 = 1'b1;
        @(posedge clk);
        #1;
        st4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); sg4 = 1'($urandom);
        while (n <= 20) begin
            @(negedge clk);
            n++;
            if (done4) break;
        end
        check("w4_lat", 64'(n), 64'd5);
        check("w4_q", 64'(q4), ref_mul(longint'(a), longint'(b), s, 4));
    endtask

    initial begin
        int n, m, stray;
        rst = 1'b1;
        st16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
        st4 = 1'b0;  sg4 = 1'b0;  a4 = '0;  b4 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy16), 64'd0);
        check("rst_done", 64'(done16), 64'd0);
        check("rst_q", 64'(q16), 64'd0);
        check("rst_q4", 64'(q4), 64'd0);
        rst = 1'b0;

        op16(16'd3, 16'd5, 1'b0, "u3x5");
        op16(16'hFFFF, 16'hFFFF, 1'b0, "uffff");
        op16(16'hFFFF, 16'hFFFF, 1'b1, "sffff");
        op16(16'h8000, 16'h8000, 1'b1, "smin");
        op16(16'hFFFD, 16'd7, 1'b1, "sm3x7");
        op16(16'd0, 16'h1234, 1'b1, "zeroa");
        op16(16'h8000, 16'd0, 1'b1, "zerob");

        // Ignored start mid-CALC, then back-to-back start in the done cycle.
        @(negedge clk);
        a16 = 16'd2; b16 = 16'd2; sg16 = 1'b0; st16 = 1'b1;
        @(posedge clk);
        #1 st16 = 1'b0;
        n = 0;
        while (n <= 40) begin
            @(negedge clk);
            n++;
            if (n == 5) begin a16 = 16'd9; b16 = 16'd9; st16 = 1'b1; end
            if (n == 6) st16 = 1'b0;
            if (done16) break;
        end
        check("b2b_lat1", 64'(n), 64'd17);
        check("b2b_q1", 64'(q16), 64'd4);
        a16 = 16'd4; b16 = 16'd4; st16 = 1'b1;
        @(posedge clk);
        #1 st16 = 1'b0;
        m = 0;
        while (m <= 40) begin
            @(negedge clk);
            m++;
            if (done16) break;
        end
        check("b2b_lat2", 64'(m), 64'd17);
        check("b2b_q2", 64'(q16), 64'd16);

        // Reset in cycle 8 of CALC, with a coincident start that must be ignored.
        @(negedge clk);
        a16 = 16'd1234; b16 = 16'd567; sg16 = 1'b0; st16 = 1'b1;
        @(posedge clk);
        #1 st16 = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        rst = 1'b1; st16 = 1'b1;
        @(negedge clk);
        rst = 1'b0; st16 = 1'b0;
        check("abort_busy", 64'(busy16), 64'd0);
        check("abort_q", 64'(q16), 64'd0);
        check("abort_done", 64'(done16), 64'd0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done16 || busy16) stray++;
        end
        check("abort_quiet", 64'(stray), 64'd0);
        op16(16'd1234, 16'd567, 1'b0, "after_rst");

        for (int i = 0; i < 40; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), "rand16");

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    op4(4'(a), 4'(b), 1'(s));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a new multiply; sampled on the rising clk edge.
REQ-006 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 A  input  WIDTH  multiplicand; sampled with start.
REQ-008 B  input  WIDTH  multiplier; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress (CALC state).
REQ-010 done  output  1  one-cycle pulse; Q is valid from this cycle onward.
REQ-011 Q  output  2*WIDTH  product; holds its value until the next done.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE: start=1 SHALL latch A, B and is_signed and go to CALC; otherwise stay in IDLE.
REQ-014 On latch with is_signed=1, the block SHALL store |A| and |B| as WIDTH-bit unsigned magnitudes and store neg = A[WIDTH-1]^B[WIDTH-1].
REQ-015 On latch with is_signed=0, the block SHALL store A and B unchanged and set neg=0.
REQ-016 On latch, the block SHALL clear the 2*WIDTH accumulator and load the bit counter with WIDTH.
REQ-017 The magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1) and SHALL not overflow the WIDTH-bit unsigned register.
REQ-018 CALC, each cycle: radix-2 shift-add; add the multiplicand magnitude to the upper accumulator half if the current multiplier LSB is 1, then shift right one bit (carry kept, WIDTH+1-bit add); the counter decrements by 1.
REQ-019 CALC SHALL last exactly WIDTH cycles, then go to DONE.
REQ-020 On the CALC->DONE edge, Q SHALL load the accumulator, two's-complement negated if neg=1.
REQ-021 done SHALL be high for exactly the DONE cycle.
REQ-022 Latency SHALL be fixed and data-independent: done is high WIDTH+1 cycles after the edge that sampled start.
REQ-023 DONE: start=1 SHALL be accepted as in IDLE (back-to-back operation, go to CALC); otherwise go to IDLE.
REQ-024 start while in CALC SHALL be ignored; latched operands and progress SHALL be unaffected.
REQ-025 A, B and is_signed changing after the sampling edge SHALL have no effect on the result.
REQ-026 An operand of zero SHALL still take the full latency and produce Q=0, with no negative zero.
REQ-027 The result SHALL be exact for all operands: unsigned 0..(2^WIDTH-1)^2; signed range fits 2*WIDTH bits.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, Q=0, accumulator=0, counter=0 and neg=0.
REQ-029 rst SHALL take priority over start and over any in-flight operation.
REQ-030 A reset during CALC SHALL abort the operation with no done pulse and no Q update.
REQ-031 start asserted in the same cycle as rst SHALL be ignored.

Verification (WIDTH=16 unless noted)
REQ-032 Unsigned A=3, B=5, start one cycle -> busy for 16 cycles, done pulses in cycle 17, Q=0x0000000F.
REQ-033 Unsigned A=B=0xFFFF -> Q=0xFFFE0001; the same operands signed -> Q=0x00000001.
REQ-034 Signed A=0x8000, B=0x8000 -> Q=0x40000000; signed A=0xFFFD (-3), B=7 -> Q=0xFFFFFFEB.
REQ-035 Start with A=2, B=2; pulse start with A=9, B=9 in cycle 5; start again in the done cycle with A=4, B=4 -> Q=4, then Q=16 seventeen cycles later; the cycle-5 start is ignored.
REQ-036 Reset in cycle 8 of CALC -> busy=0 and Q=0 next cycle, no done; a fresh start then completes normally.
REQ-037 WIDTH=4 random sweep of all signed and unsigned operand pairs -> every Q matches the reference product; done is always at cycle 5.
